// File: rtl/dpd1000_decode_seq.sv
// dpd1000_decode_seq
// Sequential binary-declet-to-BCD converter. N packed 10-bit declets are
// converted one bit per clock through a single shared double-dabble
// datapath (10 cycles per declet), then presented behind a valid/ready
// handshake.
// Build option: define DPD_DECODE_CHECK_EN to flag declets above 999
// (group forced to 12'h999, sticky inv). Without it, inv is tied to 0 and
// out-of-range declets yield (value mod 1000) in BCD.
module dpd1000_decode_seq #(
    parameter int N = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10*N-1:0]   din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [12*N-1:0]   dout,
    output logic              inv
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [10*N-1:0]   din_q;
    logic [11:0]       acc_q;
    logic [3:0]        d_q;
    logic [3:0]        b_q;
    logic [12*N-1:0]   dout_q;

    logic [9:0]        cur_declet;
    logic [2:0]        hund_adj;
    logic [3:0]        tens_adj;
    logic [3:0]        unit_adj;
    logic [11:0]       acc_next;
    logic [11:0]       group_val;
    logic              last_bit;
    logic              last_declet;

`ifdef DPD_DECODE_CHECK_EN
    logic              bad_q;
    logic              inv_q;
`endif

    // One double-dabble step on the selected declet, MSB first.
    always_comb begin
        cur_declet  = din_q[int'(d_q)*10 +: 10];
        // The hundreds digit keeps only 3 bits: its carry out of bit 11 is
        // discarded, which is what makes 1000..1023 wrap to value mod 1000.
        hund_adj    = acc_q[10:8] + ((acc_q[11:8] >= 4'd5) ? 3'd3 : 3'd0);
        tens_adj    = (acc_q[7:4] >= 4'd5) ? acc_q[7:4] + 4'd3 : acc_q[7:4];
        unit_adj    = (acc_q[3:0] >= 4'd5) ? acc_q[3:0] + 4'd3 : acc_q[3:0];
        acc_next    = {hund_adj, tens_adj, unit_adj, cur_declet[4'd9 - b_q]};
        last_bit    = (b_q == 4'd9);
        last_declet = (d_q == 4'(N - 1));
`ifdef DPD_DECODE_CHECK_EN
        group_val   = bad_q ? 12'h999 : acc_next;
`else
        group_val   = acc_next;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of
        // inferred latches on every path through the case.
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (last_bit && last_declet) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift while in SHIFT, write groups.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the result register is reset because dout must read 0
            // after reset; the capture register is cleared only for
            // determinism, nothing observes it before the next accept.
            din_q  <= '0;
            acc_q  <= '0;
            d_q    <= '0;
            b_q    <= '0;
            dout_q <= '0;
`ifdef DPD_DECODE_CHECK_EN
            bad_q  <= 1'b0;
            inv_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        din_q <= din;
                        acc_q <= '0;
                        d_q   <= '0;
                        b_q   <= '0;
`ifdef DPD_DECODE_CHECK_EN
                        bad_q <= 1'b0;
                        inv_q <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
`ifdef DPD_DECODE_CHECK_EN
                    if (b_q == 4'd0) begin
                        bad_q <= (cur_declet > 10'd999);
                        inv_q <= inv_q | (cur_declet > 10'd999);
                    end
`endif
                    if (last_bit) begin
                        dout_q[int'(d_q)*12 +: 12] <= group_val;
                        acc_q <= '0;
                        b_q   <= '0;
                        d_q   <= d_q + 4'd1;
                    end else begin
                        acc_q <= acc_next;
                        b_q   <= b_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dout      = dout_q;

`ifdef DPD_DECODE_CHECK_EN
    assign inv = inv_q;
`else
    assign inv = 1'b0;
`endif

endmodule

// File: tb/tb_dpd1000_decode_seq.sv
// Testbench for dpd1000_decode_seq: one N=2 and one N=11 instance, with a
// scoreboard filled at each accepted transaction and drained at each result
// handshake, plus direct checks of the corner cases.
`timescale 1ns/1ps
module tb_dpd1000_decode_seq;

    typedef struct {
        logic [191:0] dout;
        logic         inv;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // N=2 instance signals
    logic         iv_a, ir_a, ov_a, or_a, inv_a;
    logic [19:0]  din_a;
    logic [23:0]  dout_a;
    // N=11 instance signals
    logic         iv_b, ir_b, ov_b, or_b, inv_b;
    logic [109:0] din_b;
    logic [131:0] dout_b;

    dpd1000_decode_seq #(.N(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .din(din_a),
        .out_valid(ov_a), .out_ready(or_a), .dout(dout_a), .inv(inv_a)
    );

    dpd1000_decode_seq #(.N(11)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .din(din_b),
        .out_valid(ov_b), .out_ready(or_b), .dout(dout_b), .inv(inv_b)
    );

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   b2b_mode = 1'b0;
    int   last_acc_a = -1;
    logic prev_ov_a = 1'b0;
    logic prev_ov_b = 1'b0;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model: plain decimal arithmetic per declet.
    function automatic exp_t model(input logic [159:0] d, input int n);
        exp_t e;
        e.dout = '0;
        e.inv  = 1'b0;
        e.cyc  = 0;
        for (int g = 0; g < n; g++) begin
            int v;
            int r;
            v = int'(d[g*10 +: 10]);
`ifdef DPD_DECODE_CHECK_EN
            if (v > 999) begin
                r = 999;
                e.inv = 1'b1;
            end else begin
                r = v;
            end
`else
            r = v % 1000;
`endif
            e.dout[g*12 +: 12] = {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
        end
        return e;
    endfunction

    // Scoreboard push at each accept (handshake seen before the edge).
    always @(negedge clk) begin
        exp_t e;
        if (!rst && iv_a && ir_a) begin
            e = model(160'(din_a), 2);
            e.cyc = cyc + 1;
            sb_a.push_back(e);
            if (b2b_mode && last_acc_a >= 0)
                check("b2b_spacing", 192'(e.cyc - last_acc_a), 192'(22));
            last_acc_a = e.cyc;
        end
        if (!rst && iv_b && ir_b) begin
            e = model(160'(din_b), 11);
            e.cyc = cyc + 1;
            sb_b.push_back(e);
        end
    end

    // Scoreboard pop and compare at each result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ov_a && !prev_ov_a && sb_a.size() > 0)
                check("latency_a", 192'(cyc - sb_a[0].cyc), 192'(20));
            if (ov_a && or_a) begin
                if (sb_a.size() == 0) check("unexpected_out_a", 192'(1), 192'(0));
                else begin
                    e = sb_a.pop_front();
                    check("dout_a", 192'(dout_a), e.dout);
                    check("inv_a", 192'(inv_a), 192'(e.inv));
                end
            end
            if (ov_b && !prev_ov_b && sb_b.size() > 0)
                check("latency_b", 192'(cyc - sb_b[0].cyc), 192'(110));
            if (ov_b && or_b) begin
                if (sb_b.size() == 0) check("unexpected_out_b", 192'(1), 192'(0));
                else begin
                    e = sb_b.pop_front();
                    check("dout_b", 192'(dout_b), e.dout);
                    check("inv_b", 192'(inv_b), 192'(e.inv));
                end
            end
        end
        prev_ov_a = ov_a;
        prev_ov_b = ov_b;
    end

    task automatic send_a(input logic [19:0] d);
        int k = 0;
        @(posedge clk); #1;
        while (!ir_a && k < 500) begin @(posedge clk); #1; k++; end
        if (!ir_a) check("send_a_timeout", 192'(0), 192'(1));
        iv_a = 1'b1;
        din_a = d;
        @(posedge clk); #1;
        iv_a = 1'b0;
    endtask

    task automatic send_b(input logic [109:0] d);
        int k = 0;
        @(posedge clk); #1;
        while (!ir_b && k < 500) begin @(posedge clk); #1; k++; end
        if (!ir_b) check("send_b_timeout", 192'(0), 192'(1));
        iv_b = 1'b1;
        din_b = d;
        @(posedge clk); #1;
        iv_b = 1'b0;
    endtask

    task automatic drain_a();
        int k = 0;
        while ((sb_a.size() != 0 || !ir_a) && k < 500) begin @(posedge clk); #1; k++; end
        if (k >= 500) check("drain_a_timeout", 192'(0), 192'(1));
    endtask

    task automatic drain_b();
        int k = 0;
        while ((sb_b.size() != 0 || !ir_b) && k < 500) begin @(posedge clk); #1; k++; end
        if (k >= 500) check("drain_b_timeout", 192'(0), 192'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [109:0] db;
        logic [19:0]  vals [6];
        int k;

        rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0; or_a = 1'b1; or_b = 1'b1;
        din_a = '0; din_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_in_ready_a", 192'(ir_a), 192'(1));
        check("rst_out_valid_a", 192'(ov_a), 192'(0));
        check("rst_dout_a", 192'(dout_a), 192'(0));
        check("rst_inv_a", 192'(inv_a), 192'(0));
        check("rst_in_ready_b", 192'(ir_b), 192'(1));
        check("rst_dout_b", 192'(dout_b), 192'(0));

        // Basic N=2 transaction
        send_a({10'd123, 10'd45});
        drain_a();
        check("basic_dout", 192'(dout_a), 192'(24'h123045));
        check("basic_inv", 192'(inv_a), 192'(0));

        // N=11 extremes
        send_b({11{10'd999}});
        drain_b();
        check("all999", 192'(dout_b), 192'({11{12'h999}}));
        send_b({11{10'd0}});
        drain_b();
        check("all000", 192'(dout_b), 192'({11{12'h000}}));

        // Sweep: every value 0..999 appears in some declet position
        for (int v = 0; v < 1000; v += 11) begin
            for (int g = 0; g < 11; g++) db[g*10 +: 10] = 10'((v + g) % 1000);
            send_b(db);
        end
        for (int g = 0; g < 11; g++) db[g*10 +: 10] = 10'(1000 + 2 * g);
        send_b(db);
        drain_b();

        // Out-of-range declet
        send_a({10'd1023, 10'd7});
        drain_a();
`ifdef DPD_DECODE_CHECK_EN
        check("oor_dout", 192'(dout_a), 192'(24'h999007));
        check("oor_inv", 192'(inv_a), 192'(1));
`else
        check("oor_dout", 192'(dout_a), 192'(24'h023007));
        check("oor_inv", 192'(inv_a), 192'(0));
`endif

        // Backpressure: hold result 15 cycles, ignore a second in_valid
        or_a = 1'b0;
        send_a({10'd321, 10'd654});
        k = 0;
        while (!ov_a && k < 100) begin @(posedge clk); #1; k++; end
        check("bp_out_valid", 192'(ov_a), 192'(1));
        for (int i = 0; i < 15; i++) begin
            if (i == 5) begin iv_a = 1'b1; din_a = {10'd11, 10'd22}; end
            if (i == 6) iv_a = 1'b0;
            @(posedge clk); #1;
            check("bp_dout", 192'(dout_a), 192'(24'h321654));
            check("bp_in_ready", 192'(ir_a), 192'(0));
        end
        or_a = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 192'(ir_a), 192'(1));
        check("bp_release_out_valid", 192'(ov_a), 192'(0));
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_second", 192'(ir_a), 192'(1));
        check("bp_sb_empty", 192'(sb_a.size()), 192'(0));

        // Reset mid-SHIFT (reset edge is cycle 7 of 20)
        send_a({10'd123, 10'd45});
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_a.delete();
        check("abort_out_valid", 192'(ov_a), 192'(0));
        check("abort_dout", 192'(dout_a), 192'(0));
        check("abort_in_ready", 192'(ir_a), 192'(1));
        send_a({10'd500, 10'd501});
        drain_a();
        check("after_abort_dout", 192'(dout_a), 192'(24'h500501));

        // Back-to-back with in_valid and out_ready held high
        vals[0] = {10'd1, 10'd2};     vals[1] = {10'd998, 10'd999};
        vals[2] = {10'd100, 10'd10};  vals[3] = {10'd555, 10'd444};
        vals[4] = {10'd909, 10'd90};  vals[5] = {10'd0, 10'd789};
        b2b_mode = 1'b1;
        last_acc_a = -1;
        @(posedge clk); #1;
        din_a = vals[0];
        iv_a = 1'b1;
        for (int t = 1; t < 6; t++) begin
            k = 0;
            while (ir_a && k < 100) begin @(posedge clk); #1; k++; end
            k = 0;
            while (!ir_a && k < 100) begin @(posedge clk); #1; k++; end
            if (!ir_a) check("b2b_timeout", 192'(0), 192'(1));
            din_a = vals[t];
        end
        k = 0;
        while (ir_a && k < 100) begin @(posedge clk); #1; k++; end
        iv_a = 1'b0;
        b2b_mode = 1'b0;
        drain_a();

        check("final_sb_a", 192'(sb_a.size()), 192'(0));
        check("final_sb_b", 192'(sb_b.size()), 192'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dpd1000_decode_seq.md
# dpd1000_decode_seq

Sequential binary-declet-to-BCD converter; inverse of the team's combinational declet encoder. Takes N packed 10-bit declets (each a binary value 0..999) and returns N packed 3-digit BCD groups, computed with a single shared double-dabble datapath, one bit per clock. Sits on the output side of the decimal float unit, converting the coefficient back to BCD digits for formatting and storage, behind a valid/ready handshake.

## Interface
- N, 11, number of declets per transaction (1..16)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  `din` is valid
- in_ready  output  1  block is idle and accepts a transaction
- din  input  10*N  packed declets; declet g at `din[g*10+9:g*10]`
- out_valid  output  1  `dout`/`inv` hold a completed result
- out_ready  input  1  consumer accepts the result
- dout  output  12*N  packed BCD; group g at `dout[g*12+11:g*12]` (hundreds `[11:8]`, tens `[7:4]`, units `[3:0]`)
- inv  output  1  at least one declet exceeded 999 (checking build only)

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE: `in_ready`=1. On `in_valid`: capture `din`, clear BCD accumulator, set declet index d=0, bit count b=0, clear `inv`, go to SHIFT.
  - SHIFT: each cycle performs one double-dabble step on declet d, MSB first:
    - add 3 to every BCD digit ≥5;
    - shift the 12-bit accumulator left, bringing in bit 9-b of declet d;
    - any carry out of bit 11 is discarded.
    - After b=9, write the accumulator to group d, clear it, set b=0 and d=d+1. After d=N-1 completes, go to DONE.
  - DONE: `out_valid`=1 and `dout`/`inv` are stable. On `out_ready`, go to IDLE.
- `in_ready`=1 only in IDLE. There is no overlap of transactions. `din` is ignored outside the IDLE accept cycle.
- Declets are processed in index order 0..N-1. Groups that are not yet written keep their previous value; they are not observable until `out_valid`.
- Declet values 1000..1023: behaviour is set by the macro (see Configuration).
- Reset values: `in_ready`=1 in the cycle after reset, `out_valid`=0, `dout`=0, `inv`=0, state IDLE.
- `rst` during SHIFT or DONE aborts the transaction and discards partial results. An unconsumed result is lost.

## Timing
- Accept at edge 0 (IDLE, `in_valid`=1).
- SHIFT occupies edges 1..10*N. `out_valid` is visible after edge 10*N, so latency is 10*N cycles from the accept edge.
- With `out_ready` held at 1: the pop occurs at edge 10*N+1, `in_ready` rises after it, and the next accept is no earlier than edge 10*N+2. Peak throughput is one transaction per 10*N+2 cycles.
- `out_valid` stays asserted with `dout` unchanged for as long as `out_ready`=0.
- `in_valid` and `out_ready` may both be high: in DONE only `out_ready` matters; in IDLE only `in_valid` matters.

## Configuration
- Macro: `DPD_DECODE_CHECK_EN`.
  - Defined: when declet d is selected at b=0, compare it against 999. If it exceeds 999, the group result is forced to 12'h999 and `inv` is set (sticky until the next accept). Cycle count is unchanged.
  - Undefined: `inv` is tied to 0. Out-of-range declets run through the plain datapath and yield (value mod 1000) in BCD; for example, 1023 gives 12'h023.

## Test plan
- N=2, `din`={10'd123,10'd45}, `out_ready`=1: `out_valid` rises exactly 20 cycles after the accept edge, `dout`=24'h123_045, `inv`=0.
- N=11, all declets 10'd999, then all 10'd0: `dout`=all 12'h999, then all 12'h000. Repeat with a sweep of 0..999 in declet 0, comparing against a reference model.
- N=2, `din`={10'd1023,10'd7}:
  - with `DPD_DECODE_CHECK_EN`: `dout`=24'h999_007, `inv`=1;
  - without it: `dout`=24'h023_007, `inv`=0.
- Backpressure: hold `out_ready`=0 for 15 cycles after `out_valid` rises. `dout` must stay stable, `in_ready` must stay 0, and a second `in_valid` pulse must be ignored. Release `out_ready`: `in_ready`=1 on the following cycle.
- Assert `rst` in the middle of SHIFT (cycle 7 of 20, N=2). The next cycle must show `out_valid`=0, `dout`=0, `in_ready`=1. A new transaction {10'd500,10'd501} then returns 24'h500_501.
- Back-to-back transactions with `in_valid` and `out_ready` held at 1: accepts are spaced exactly 10*N+2 cycles apart, and each result matches its own input.
